// File: rtl/arm_mc_controller.sv
// Purpose : multicycle control FSM for the 32-bit ARM-subset datapath (flags, CondEx, enables, mux selects).
// Latency : DP 4, LDR 5, STR 4, B 3, undefined 2 cycles per instruction; outputs are Moore (state + cx).
// Backpress: none; the FSM advances every cycle, and write enables are forced low while rst_n is low.
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   Op, Funct, Rd, Cond      instruction fields from the instruction register
//   ALUFlag                  {N,Z,C,V} from the ALU, sampled at the end of execute states
//   ALUControl               00 ADD, 01 SUB, 10 AND, 11 OR
//   PCWrite/MemWrite/RegWrite/IRWrite   write enables
//   AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc   datapath mux selects
//   Flags                    architectural {N,Z,C,V}
//   Undef                    undefined-instruction indicator
//
// Build option: define CTRL_UNDEF_TRAP_EN to trap undefined instructions in a sticky HALT state.
module arm_mc_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlag,
  output logic [1:0] ALUControl,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] Flags,
  output logic       Undef
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWRITE = 4'd4,
    S_MEMWB    = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_HALT     = 4'd10
  } state_t;

  state_t     state, state_nxt;
  logic       cx;
  logic [3:0] flags_q;

  logic       cmd_ok;
  logic [1:0] cmd_alu;
  logic       cmd_arith;

  logic       pcw_s, memw_s, regw_s, irw_s;

  // Condition-code evaluation against the stored flags.
  function automatic logic condex(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    logic r;
    {n, z, cf, v} = f;
    case (c)
      4'b0000: r = z;
      4'b0001: r = !z;
      4'b0010: r = cf;
      4'b0011: r = !cf;
      4'b0100: r = n;
      4'b0101: r = !n;
      4'b0110: r = v;
      4'b0111: r = !v;
      4'b1000: r = cf & !z;
      4'b1001: r = !cf | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = !z & (n == v);
      4'b1101: r = z | (n != v);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    cmd_ok    = 1'b1;
    cmd_alu   = 2'b00;
    cmd_arith = 1'b0;
    case (Funct[4:1])
      4'b0100: begin cmd_alu = 2'b00; cmd_arith = 1'b1; end
      4'b0010: begin cmd_alu = 2'b01; cmd_arith = 1'b1; end
      4'b0000: cmd_alu = 2'b10;
      4'b1100: cmd_alu = 2'b11;
      default: cmd_ok = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // cx folds the condition check and, for data-processing, cmd support,
  // so a single bit gates every write of the instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx <= 1'b0;
    end else if (state == S_DECODE) begin
      cx <= condex(Cond, flags_q) & ((Op != 2'b00) | cmd_ok);
    end
  end

  // Flags register: only written at the end of a data-processing execute.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if ((state == S_EXECR || state == S_EXECI) && cx && Funct[0]) begin
      if (cmd_arith) flags_q <= ALUFlag;
      else           flags_q[3:2] <= ALUFlag[3:2];
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00: begin
`ifdef CTRL_UNDEF_TRAP_EN
            if (!cmd_ok)        state_nxt = S_HALT;
            else if (Funct[5])  state_nxt = S_EXECI;
            else                state_nxt = S_EXECR;
`else
            state_nxt = Funct[5] ? S_EXECI : S_EXECR;
`endif
          end
          2'b01:   state_nxt = S_MEMADR;
          2'b10:   state_nxt = S_BRANCH;
          default: begin
`ifdef CTRL_UNDEF_TRAP_EN
            state_nxt = S_HALT;
`else
            state_nxt = S_FETCH;
`endif
          end
        endcase
      end
      S_MEMADR:   state_nxt = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_nxt = S_MEMWB;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: state_nxt = S_FETCH;
      S_EXECR:    state_nxt = S_ALUWB;
      S_EXECI:    state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = S_FETCH;
      S_HALT:     state_nxt = S_HALT;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // Moore outputs
  always_comb begin
    ALUControl = 2'b00;
    pcw_s      = 1'b0;
    memw_s     = 1'b0;
    regw_s     = 1'b0;
    irw_s      = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    case (state)
      S_FETCH: begin
        irw_s     = 1'b1;
        pcw_s     = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR:   ALUSrcB = 2'b01;
      S_MEMREAD:  AdrSrc  = 1'b1;
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        memw_s = cx;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        regw_s    = cx & (Rd != 4'd15);
        pcw_s     = cx & (Rd == 4'd15);
      end
      S_EXECR: ALUControl = cmd_alu;
      S_EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = cmd_alu;
      end
      S_ALUWB: begin
        regw_s = cx & (Rd != 4'd15);
        pcw_s  = cx & (Rd == 4'd15);
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pcw_s     = cx;
      end
      default: ;
    endcase
  end

  // Reset parks the FSM in FETCH, whose enables are active; mask them while
  // rst_n is low so nothing is written during or at the edge of reset.
  assign PCWrite  = pcw_s  & rst_n;
  assign MemWrite = memw_s & rst_n;
  assign RegWrite = regw_s & rst_n;
  assign IRWrite  = irw_s  & rst_n;

  assign ImmSrc = Op;
  assign RegSrc = {Op == 2'b01, Op == 2'b10};
  assign Flags  = flags_q;

`ifdef CTRL_UNDEF_TRAP_EN
  assign Undef = (state == S_HALT);
`else
  assign Undef = 1'b0;
`endif

endmodule

// File: tb/tb_arm_mc_controller.sv
// Purpose : self-checking bench for arm_mc_controller against an instruction-level model.
// Latency : model predicts every output for every cycle of each instruction.
// Backpress: not applicable; stimulus advances one instruction at a time.
module tb_arm_mc_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'd0;
  logic [3:0] Rd = 4'd0;
  logic [3:0] Cond = 4'd0;
  logic [3:0] ALUFlag = 4'd0;
  logic [1:0] ALUControl;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [3:0] Flags;
  logic       Undef;

  arm_mc_controller dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond),
    .ALUFlag(ALUFlag), .ALUControl(ALUControl), .PCWrite(PCWrite),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .Flags(Flags), .Undef(Undef)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] aluc;
    logic       pcw;
    logic       memw;
    logic       regw;
    logic       irw;
    logic       adrsrc;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic [1:0] immsrc;
    logic [1:0] regsrc;
    logic [3:0] flags;
    logic       undef;
  } out_t;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] mflags = 4'b0000;
  out_t       cap [5];

  function automatic out_t sample();
    out_t s;
    s.aluc = ALUControl; s.pcw = PCWrite; s.memw = MemWrite; s.regw = RegWrite;
    s.irw = IRWrite; s.adrsrc = AdrSrc; s.srca = ALUSrcA; s.srcb = ALUSrcB;
    s.res = ResultSrc; s.immsrc = ImmSrc; s.regsrc = RegSrc; s.flags = Flags;
    s.undef = Undef;
    return s;
  endfunction

  task automatic check_out(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- instruction-level model ----------------
  function automatic bit cmd_ok(input logic [3:0] c);
    return (c == 4'b0100) || (c == 4'b0010) || (c == 4'b0000) || (c == 4'b1100);
  endfunction

  function automatic logic [1:0] cmd_alu(input logic [3:0] c);
    if (c == 4'b0010) return 2'b01;
    if (c == 4'b0000) return 2'b10;
    if (c == 4'b1100) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int instr_len(input logic [1:0] op, input logic [5:0] fn);
    case (op)
      2'd0: return 4;
      2'd1: return fn[0] ? 5 : 4;
      2'd2: return 3;
      default: return 2;
    endcase
  endfunction

  // Expected outputs for cycle k (0 = fetch) of an instruction.
  function automatic out_t expect_cycle(input int k, input logic [1:0] op, input logic [5:0] fn,
                                        input logic [3:0] rd, input bit cx, input logic [3:0] fl);
    out_t e;
    e = '0;
    e.immsrc = op;
    e.regsrc = {op == 2'd1, op == 2'd2};
    e.flags  = fl;
    if (k == 0) begin
      e.irw = 1; e.pcw = 1; e.srca = 1; e.srcb = 2'b10; e.res = 2'b10;
    end else if (k == 1) begin
      e.srca = 1; e.srcb = 2'b10; e.res = 2'b10;
    end else if (op == 2'd0) begin
      if (k == 2) begin
        e.srcb = fn[5] ? 2'b01 : 2'b00;
        e.aluc = cmd_alu(fn[4:1]);
      end else begin
        e.res = 2'b00; e.regw = cx && (rd != 15); e.pcw = cx && (rd == 15);
      end
    end else if (op == 2'd1) begin
      if (k == 2) e.srcb = 2'b01;
      else if (!fn[0]) begin e.adrsrc = 1; e.memw = cx; end
      else if (k == 3) e.adrsrc = 1;
      else begin e.res = 2'b01; e.regw = cx && (rd != 15); e.pcw = cx && (rd == 15); end
    end else if (op == 2'd2) begin
      e.srcb = 2'b01; e.res = 2'b10; e.pcw = cx;
    end
    return e;
  endfunction

  task automatic run_instr(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                           input logic [3:0] cond, input logic [3:0] fl, input int limit);
    int   n;
    bit   cx;
    out_t act, exp;
    n = instr_len(op, fn);
    if (limit < n) n = limit;
    cx = cond_holds(cond, mflags) && (op != 2'd0 || cmd_ok(fn[4:1]));
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) begin Op = op; Funct = fn; Rd = rd; Cond = cond; ALUFlag = fl; end
      #1;
      exp = expect_cycle(k, op, fn, rd, cx, mflags);
      act = sample();
      cap[k] = act;
      // ALU select for an unsupported cmd carries no meaning
      if (op == 2'd0 && k == 2 && !cmd_ok(fn[4:1])) begin act.aluc = 0; exp.aluc = 0; end
      check_out($sformatf("op%0d fn%02h cyc%0d", op, fn, k), act, exp);
      if (op == 2'd0 && k == 2 && cx && fn[0]) begin
        if (fn[4:1] == 4'b0100 || fn[4:1] == 4'b0010) mflags = fl;
        else mflags = {fl[3:2], mflags[1:0]};
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mflags = 4'b0000;
    #1;
    check_val("reset enables", {PCWrite, MemWrite, RegWrite, IRWrite}, 0);
    check_val("reset flags", Flags, 0);
    check_val("reset undef", Undef, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  localparam logic [3:0] AL = 4'b1110;
  localparam logic [3:0] EQ = 4'b0000;

  initial begin
    logic [1:0] rop;
    logic [5:0] rfn;
    #2;
    do_reset();

    // ADDS R1,R2,R3
    run_instr(2'd0, 6'b001001, 4'd1, AL, 4'b1001, 9);
    check_val("adds aluctl", cap[2].aluc, 2'b00);
    check_val("adds regw exec", cap[2].regw, 0);
    check_val("adds regw wb", cap[3].regw, 1);
    check_val("adds flags", Flags, 4'b1001);

    // SUBS sets Z, BEQ taken
    run_instr(2'd0, 6'b000101, 4'd2, AL, 4'b0100, 9);
    run_instr(2'd2, 6'd0, 4'd0, EQ, 4'b0000, 9);
    check_val("beq taken pcw", cap[2].pcw, 1);
    // ADDS clears flags, BEQ not taken
    run_instr(2'd0, 6'b001001, 4'd2, AL, 4'b0000, 9);
    run_instr(2'd2, 6'd0, 4'd0, EQ, 4'b0000, 9);
    check_val("beq not taken pcw", cap[2].pcw, 0);
    run_instr(2'd0, 6'b001001, 4'd3, AL, 4'b1001, 9);
    check_val("fetch after branch", cap[0].irw, 1);

    // ANDS keeps C,V
    run_instr(2'd0, 6'b000001, 4'd4, AL, 4'b0100, 9);
    check_val("ands flags", Flags, 4'b0101);

    // LDR PC
    run_instr(2'd1, 6'b000001, 4'd15, AL, 4'b0000, 9);
    check_val("ldr pc pcw", cap[4].pcw, 1);
    check_val("ldr pc regw", cap[4].regw, 0);
    check_val("ldr pc res", cap[4].res, 2'b01);
    // STR
    run_instr(2'd1, 6'b000000, 4'd5, AL, 4'b0000, 9);
    check_val("str memw addr", cap[2].memw, 0);
    check_val("str memw", cap[3].memw, 1);

`ifdef CTRL_UNDEF_TRAP_EN
    run_instr(2'd3, 6'd0, 4'd0, AL, 4'b0000, 9);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check_val("halt undef", Undef, 1);
      check_val("halt enables", {PCWrite, MemWrite, RegWrite, IRWrite}, 0);
    end
    do_reset();
    mflags = 4'b0000;
`else
    run_instr(2'd3, 6'd0, 4'd0, AL, 4'b0000, 9);
    run_instr(2'd0, 6'b001000, 4'd6, AL, 4'b0000, 9);
    check_val("fetch after undef", cap[0].irw, 1);
    // unsupported cmd: no writes, no flag change
    run_instr(2'd0, 6'b011111, 4'd3, AL, 4'b1111, 9);
    check_val("unsup regw", cap[3].regw, 0);
    check_val("unsup flags", Flags, 4'b0101);
`endif

    // reset during MEMWRITE (flags currently non-zero unless trapped above)
    run_instr(2'd0, 6'b001001, 4'd1, AL, 4'b1010, 9);
    run_instr(2'd1, 6'b000000, 4'd5, AL, 4'b0000, 4);
    check_val("memwrite before abort", cap[3].memw, 1);
    #1 rst_n = 1'b0;
    mflags = 4'b0000;
    #1;
    check_val("abort memw", MemWrite, 0);
    check_val("abort flags", Flags, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_instr(2'd0, 6'b001000, 4'd7, AL, 4'b0000, 9);
    check_val("release fetch", cap[0].irw, 1);
    check_val("release flags", cap[0].flags, 0);

    // randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      rop = 2'($urandom_range(0, 3));
      rfn = 6'($urandom);
`ifdef CTRL_UNDEF_TRAP_EN
      if (rop == 2'd3) rop = 2'd2;
      if (rop == 2'd0 && !cmd_ok(rfn[4:1])) rfn[4:1] = 4'b0100;
`endif
      run_instr(rop, rfn, ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom),
                4'($urandom), 4'($urandom), 9);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
